// File: rtl/alarm_ringer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ringer
// Description : Buzzer driver for the alarm. Starts ringing on a rising edge
//               of the alarm match level and beeps 1 s on / 1 s off. Supports
//               a limited number of snoozes with re-ring, dismiss, and an
//               auto-timeout. Time base is the Clock seconds value.
//               Optional volume ramp output: define ALARM_RINGER_VOLUME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ringer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alarm_in,
    input  logic [5:0]                      sec_in,
    input  logic                            snooze,
    input  logic                            dismiss,
    output logic                            buzzer,
    output logic                            ringing,
    output logic                            snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_count,
`ifdef ALARM_RINGER_VOLUME_EN
    output logic [1:0]                      volume,
`endif
    output logic                            timed_out
);

    // Counter widths; a limit of 1 still needs one bit to hold the value 0.
    localparam int RC_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int SN_W = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam int SC_W = $clog2(MAX_SNOOZE + 1);

    localparam logic [RC_W-1:0] RING_LAST   = RC_W'(RING_SECS - 1);
    localparam logic [SN_W-1:0] SNOOZE_LAST = SN_W'(SNOOZE_SECS - 1);
    localparam logic [SC_W-1:0] SNOOZE_MAX  = SC_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        sec_prev_q, sec_prev_d;
    logic              alarm_q, alarm_d;
    logic [RC_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [SN_W-1:0]   snooze_cnt_q, snooze_cnt_d;
    logic [SC_W-1:0]   snooze_count_q, snooze_count_d;
    logic              phase_q, phase_d;
    logic              buzzer_q, buzzer_d;
    logic              ringing_q, ringing_d;
    logic              snoozing_q, snoozing_d;
    logic              timed_out_q, timed_out_d;

    logic              tick;
    logic              rise;

    // A change of the seconds value marks one elapsed second (59->0 included).
    assign tick = (sec_in != sec_prev_q);
    assign rise = alarm_in & ~alarm_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d        = state_q;
        sec_prev_d     = sec_in;
        alarm_d        = alarm_in;
        ring_cnt_d     = ring_cnt_q;
        snooze_cnt_d   = snooze_cnt_q;
        snooze_count_d = snooze_count_q;
        phase_d        = phase_q;
        timed_out_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d        = ST_RINGING;
                    ring_cnt_d     = '0;
                    phase_d        = 1'b1;
                    snooze_count_d = '0;
                end
            end
            ST_RINGING: begin
                if (dismiss) begin
                    state_d = ST_IDLE;
                end else if (snooze && (snooze_count_q < SNOOZE_MAX)) begin
                    state_d        = ST_SNOOZE;
                    snooze_cnt_d   = '0;
                    snooze_count_d = snooze_count_q + SC_W'(1);
                end else if (tick) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d     = ST_IDLE;
                        timed_out_d = 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RC_W'(1);
                        phase_d    = ~phase_q;
                    end
                end
            end
            ST_SNOOZE: begin
                if (dismiss) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (snooze_cnt_q == SNOOZE_LAST) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                        phase_d    = 1'b1;
                    end else begin
                        snooze_cnt_d = snooze_cnt_q + SN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they land with it.
        ringing_d  = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
        buzzer_d   = (state_d == ST_RINGING) & phase_d;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            sec_prev_q     <= '0;
            alarm_q        <= 1'b0;
            ring_cnt_q     <= '0;
            snooze_cnt_q   <= '0;
            snooze_count_q <= '0;
            phase_q        <= 1'b0;
            buzzer_q       <= 1'b0;
            ringing_q      <= 1'b0;
            snoozing_q     <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sec_prev_q     <= sec_prev_d;
            alarm_q        <= alarm_d;
            ring_cnt_q     <= ring_cnt_d;
            snooze_cnt_q   <= snooze_cnt_d;
            snooze_count_q <= snooze_count_d;
            phase_q        <= phase_d;
            buzzer_q       <= buzzer_d;
            ringing_q      <= ringing_d;
            snoozing_q     <= snoozing_d;
            timed_out_q    <= timed_out_d;
        end
    end

    assign buzzer       = buzzer_q;
    assign ringing      = ringing_q;
    assign snoozing     = snoozing_q;
    assign snooze_count = snooze_count_q;
    assign timed_out    = timed_out_q;

`ifdef ALARM_RINGER_VOLUME_EN
    logic [1:0] volume_q, volume_d;
    logic [3:0] vol_tick_q, vol_tick_d;

    // Volume ramp: starts at 1 on entering RINGING, steps up every 10th tick.
    always_comb begin
        volume_d   = volume_q;
        vol_tick_d = vol_tick_q;
        if (state_d != ST_RINGING) begin
            volume_d   = 2'd0;
            vol_tick_d = 4'd0;
        end else if (state_q != ST_RINGING) begin
            volume_d   = 2'd1;
            vol_tick_d = 4'd0;
        end else if (tick) begin
            if (vol_tick_q == 4'd9) begin
                vol_tick_d = 4'd0;
                if (volume_q != 2'd3) begin
                    volume_d = volume_q + 2'd1;
                end
            end else begin
                vol_tick_d = vol_tick_q + 4'd1;
            end
        end
    end

    // Volume ramp registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            volume_q   <= 2'd0;
            vol_tick_q <= 4'd0;
        end else begin
            volume_q   <= volume_d;
            vol_tick_q <= vol_tick_d;
        end
    end

    assign volume = volume_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ringer
// Description : Self-checking bench for alarm_ringer with RING_SECS=4,
//               SNOOZE_SECS=3, MAX_SNOOZE=2. Table of per-clock vectors plus
//               hand sequences for reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ringer;

    logic       clk;
    logic       reset;
    logic       alarm_in;
    logic [5:0] sec_in;
    logic       snooze;
    logic       dismiss;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic       timed_out;
`ifdef ALARM_RINGER_VOLUME_EN
    logic [1:0] volume;
`endif

    int checks = 0;
    int errors = 0;

    alarm_ringer #(
        .RING_SECS   (4),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alarm_in     (alarm_in),
        .sec_in       (sec_in),
        .snooze       (snooze),
        .dismiss      (dismiss),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_count (snooze_count),
`ifdef ALARM_RINGER_VOLUME_EN
        .volume       (volume),
`endif
        .timed_out    (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {buzzer, ringing, snoozing, snooze_count[1:0], timed_out}
    typedef struct {
        logic       a;
        logic       s;
        logic       d;
        logic [5:0] sec;
        logic [5:0] exp;
    } vec_t;

    vec_t tv[38];

    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = {buzzer, ringing, snoozing, snooze_count, timed_out};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {buz,ring,snz,cnt,to}=%b required %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Apply one clock's inputs, then sample just after the active edge.
    task automatic drive(input logic a, input logic s, input logic d, input logic [5:0] sec);
        alarm_in = a;
        snooze   = s;
        dismiss  = d;
        sec_in   = sec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               a  s  d  sec  b r s cc t
        tv[0]  = '{1'b1, 1'b0, 1'b0, 6'd10, 6'b110000}; // rise -> ringing, beep on
        tv[1]  = '{1'b1, 1'b0, 1'b0, 6'd10, 6'b110000};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 6'd11, 6'b010000}; // tick 1 -> off
        tv[3]  = '{1'b1, 1'b0, 1'b0, 6'd11, 6'b010000};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 6'd12, 6'b110000}; // tick 2 -> on
        tv[5]  = '{1'b1, 1'b0, 1'b0, 6'd13, 6'b010000}; // tick 3 -> off
        tv[6]  = '{1'b1, 1'b0, 1'b0, 6'd14, 6'b000001}; // tick 4 -> timeout
        tv[7]  = '{1'b1, 1'b0, 1'b0, 6'd14, 6'b000000}; // pulse is one clk
        tv[8]  = '{1'b0, 1'b0, 1'b0, 6'd14, 6'b000000};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 6'd14, 6'b110000}; // new rise
        tv[10] = '{1'b1, 1'b1, 1'b0, 6'd14, 6'b001010}; // snooze #1
        tv[11] = '{1'b1, 1'b0, 1'b0, 6'd58, 6'b001010}; // snooze tick 1
        tv[12] = '{1'b1, 1'b0, 1'b0, 6'd59, 6'b001010}; // snooze tick 2
        tv[13] = '{1'b0, 1'b0, 1'b0, 6'd59, 6'b001010};
        tv[14] = '{1'b1, 1'b0, 1'b0, 6'd59, 6'b001010}; // re-rise ignored
        tv[15] = '{1'b1, 1'b0, 1'b0, 6'd0,  6'b110010}; // 59->0 tick 3 -> re-ring
        tv[16] = '{1'b1, 1'b0, 1'b0, 6'd1,  6'b010010};
        tv[17] = '{1'b1, 1'b1, 1'b0, 6'd1,  6'b001100}; // snooze #2
        tv[18] = '{1'b1, 1'b1, 1'b0, 6'd1,  6'b001100}; // snooze ignored in SNOOZE
        tv[19] = '{1'b1, 1'b0, 1'b0, 6'd2,  6'b001100};
        tv[20] = '{1'b1, 1'b0, 1'b0, 6'd3,  6'b001100};
        tv[21] = '{1'b1, 1'b0, 1'b0, 6'd4,  6'b110100}; // re-ring
        tv[22] = '{1'b1, 1'b1, 1'b0, 6'd4,  6'b110100}; // 3rd snooze ignored
        tv[23] = '{1'b1, 1'b1, 1'b0, 6'd5,  6'b010100}; // ignored snooze, tick still counts
        tv[24] = '{1'b1, 1'b0, 1'b1, 6'd5,  6'b000100}; // dismiss, count held
        tv[25] = '{1'b1, 1'b0, 1'b0, 6'd5,  6'b000100};
        tv[26] = '{1'b0, 1'b0, 1'b0, 6'd5,  6'b000100};
        tv[27] = '{1'b1, 1'b0, 1'b0, 6'd5,  6'b110000}; // new rise clears count
        tv[28] = '{1'b1, 1'b1, 1'b0, 6'd6,  6'b001010}; // snooze beats tick
        tv[29] = '{1'b1, 1'b0, 1'b0, 6'd7,  6'b001010};
        tv[30] = '{1'b1, 1'b0, 1'b0, 6'd8,  6'b001010};
        tv[31] = '{1'b1, 1'b0, 1'b0, 6'd9,  6'b110010};
        tv[32] = '{1'b1, 1'b1, 1'b1, 6'd10, 6'b000010}; // dismiss beats snooze+tick
        tv[33] = '{1'b1, 1'b0, 1'b0, 6'd10, 6'b000010};
        tv[34] = '{1'b0, 1'b0, 1'b0, 6'd10, 6'b000010};
        tv[35] = '{1'b1, 1'b0, 1'b0, 6'd10, 6'b110000};
        tv[36] = '{1'b1, 1'b1, 1'b0, 6'd10, 6'b001010};
        tv[37] = '{1'b1, 1'b0, 1'b1, 6'd10, 6'b000010}; // dismiss from SNOOZE

        reset    = 1'b0;
        alarm_in = 1'b0;
        sec_in   = 6'd0;
        snooze   = 1'b0;
        dismiss  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 6'b000000);

        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 6'(i));
            check($sformatf("idle_tick%0d", i), 6'b000000);
        end

        for (int i = 0; i < 38; i++) begin
            drive(tv[i].a, tv[i].s, tv[i].d, tv[i].sec);
            check($sformatf("vec%0d", i), tv[i].exp);
        end

        // Asynchronous reset while ringing, applied between clock edges.
        drive(1'b0, 1'b0, 1'b0, 6'd10);
        drive(1'b1, 1'b0, 1'b0, 6'd10);
        check("pre_async_ring", 6'b110000);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 6'b000000);
        alarm_in = 1'b0;
        @(posedge clk);
        #1;
        check("reset_held", 6'b000000);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 6'(20 + i));
            check($sformatf("post_reset_idle%0d", i), 6'b000000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
